// File: rtl/muldiv_seq_if.sv
// Start/Busy/Done handshake and HI/LO result bus between the control unit (master) and muldiv_seq (slave).
// dbg_state mirrors the sequencer state register for checkers and debug.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    // Start is a one-cycle request, taken only when Busy=0. Busy stays high until
    // the cycle after Done. Done is a one-cycle pulse, and Hi/Lo/Err are valid in that cycle.
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic             Err;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic [1:0]       dbg_state;

    modport master (
        output Start, Op, A, B,
        input  Busy, Done, Err, Hi, Lo, dbg_state
    );

    modport slave (
        input  Start, Op, A, B,
        output Busy, Done, Err, Hi, Lo, dbg_state
    );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that owns HI/LO. It produces one result bit per cycle.
// Define MULDIV_DIV_EN to build the restoring divider. Without it, every divide is rejected with Err.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic         Clk,
    input  logic         Reset,
    muldiv_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               neg_q, neg_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
`ifdef MULDIV_DIV_EN
    logic               is_div_q, is_div_d;
    logic               rem_neg_q, rem_neg_d;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ok;
    logic [WIDTH-1:0]   quo, rem;
`endif

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               reject;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        neg_d   = neg_q;
        err_d   = 1'b0;

        // Op[0]=0 selects the signed flavour of both multiply and divide
        mag_a   = (!bus.Op[0] && bus.A[WIDTH-1]) ? -bus.A : bus.A;
        mag_b   = (!bus.Op[0] && bus.B[WIDTH-1]) ? -bus.B : bus.B;
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        prod    = neg_q ? -acc_q : acc_q;

`ifdef MULDIV_DIV_EN
        is_div_d  = is_div_q;
        rem_neg_d = rem_neg_q;
        // Partial remainder is always below the divisor, so a clean subtract leaves both top bits zero
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
        div_ok    = (div_diff[WIDTH+1:WIDTH] == 2'b00);
        quo       = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem       = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        reject    = bus.Op[1] && (bus.B == '0);
`else
        reject    = bus.Op[1];
`endif

        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    if (reject) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        // Low half holds the multiplier or the dividend. opnd holds the multiplicand or the divisor.
                        state_d = RUN;
                        cnt_d   = CNT_W'(WIDTH);
                        acc_d   = {{WIDTH{1'b0}}, (bus.Op[1] ? mag_a : mag_b)};
                        opnd_d  = bus.Op[1] ? mag_b : mag_a;
                        neg_d   = !bus.Op[0] && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
`ifdef MULDIV_DIV_EN
                        is_div_d  = bus.Op[1];
                        rem_neg_d = !bus.Op[0] && bus.A[WIDTH-1];
`endif
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
`ifdef MULDIV_DIV_EN
                if (is_div_q) begin
                    acc_d = div_ok ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                                   : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
`else
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
`endif
            end
            FIX: begin
                state_d = DONE;
`ifdef MULDIV_DIV_EN
                if (is_div_q) begin
                    hi_d = rem;
                    lo_d = quo;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
`else
                hi_d = prod[2*WIDTH-1:WIDTH];
                lo_d = prod[WIDTH-1:0];
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_q  <= 1'b0;
            rem_neg_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef MULDIV_DIV_EN
            is_div_q  <= is_div_d;
            rem_neg_q <= rem_neg_d;
`endif
        end
    end

    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.Err       = err_q;
    assign bus.Hi        = hi_q;
    assign bus.Lo        = lo_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed, table-driven bench for muldiv_seq. It also runs hand sequences for Start-while-busy,
// reset mid-operation and a Start held high. Divide expectations follow MULDIV_DIV_EN.
module tb_muldiv_seq;
    localparam int W   = 32;
    localparam int LAT = W + 1;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    muldiv_seq_if #(.WIDTH(W)) bus ();
    muldiv_seq #(.WIDTH(W)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         err;
        logic         keep;
        int           lat;
    } vec_t;

    vec_t         vecs[$];
    int           tests_run    = 0;
    int           tests_failed = 0;
    logic [W-1:0] prev_hi = '0;
    logic [W-1:0] prev_lo = '0;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic [1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] hi, input logic [W-1:0] lo,
                           input logic err, input logic keep, input int lat);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo;
        v.err = err; v.keep = keep; v.lat = lat;
        vecs.push_back(v);
    endtask

    task automatic add_div(input string name, input logic [1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] hi, input logic [W-1:0] lo);
`ifdef MULDIV_DIV_EN
        add_vec(name, op, a, b, hi, lo, 1'b0, 1'b0, LAT);
`else
        add_vec(name, op, a, b, '0, '0, 1'b1, 1'b1, 0);
`endif
    endtask

    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        tick();
        bus.Start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input logic [W-1:0] ph, input logic [W-1:0] pl,
                             output int lat, output bit seen, output bit hold_bad, output bit err_bad);
        lat = 0; hold_bad = 1'b0; err_bad = 1'b0;
        while (bus.Done !== 1'b1 && lat < max_cyc) begin
            if (bus.Err !== 1'b0) err_bad = 1'b1;
            if (bus.Hi !== ph || bus.Lo !== pl) hold_bad = 1'b1;
            tick();
            lat++;
        end
        seen = (bus.Done === 1'b1);
    endtask

    task automatic run_vec(input vec_t v);
        logic [W-1:0] exp_hi, exp_lo;
        int lat;
        bit seen, hold_bad, err_bad;
        exp_hi = v.keep ? prev_hi : v.hi;
        exp_lo = v.keep ? prev_lo : v.lo;
        start_op(v.op, v.a, v.b);
        wait_done(LAT + 8, prev_hi, prev_lo, lat, seen, hold_bad, err_bad);
        check({v.name, "_done"}, seen, 1);
        check({v.name, "_lat"}, lat, v.lat);
        check({v.name, "_hi"}, bus.Hi, exp_hi);
        check({v.name, "_lo"}, bus.Lo, exp_lo);
        check({v.name, "_err"}, bus.Err, v.err);
        check({v.name, "_hold"}, hold_bad, 0);
        check({v.name, "_err_early"}, err_bad, 0);
        tick();
        check({v.name, "_after"}, {bus.Busy, bus.Done, bus.Err}, 3'b000);
        prev_hi = exp_hi;
        prev_lo = exp_lo;
    endtask

    initial begin
        int lat, extra;
        bit seen, hold_bad, err_bad;
        vec_t v;

        add_vec("mult_neg",    OP_MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0, LAT);
        add_vec("multu_max",   OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, LAT);
        add_vec("mult_m1m1",   OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 1'b0, LAT);
        add_vec("multu_shift", OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 1'b0, LAT);
        add_vec("mult_minmin", OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, LAT);
        add_vec("mult_min1",   OP_MULT,  32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, LAT);
        add_vec("multu_zero",  OP_MULTU, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 1'b0, 1'b0, LAT);
        add_div("div_neg",     OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        add_div("div_ovf",     OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        add_div("divu_100_7",  OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14);
        add_div("div_pos_neg", OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD);
        add_div("divu_by1",    OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF);
        add_div("divu_small",  OP_DIVU,  32'd3,        32'd10,       32'd3,        32'd0);
        // 0xE6666669 * 0x14 = 0x12_00000034, which preloads Hi/Lo with 0x12/0x34
        add_vec("preload",     OP_MULTU, 32'hE6666669, 32'h00000014, 32'h00000012, 32'h00000034, 1'b0, 1'b0, LAT);
        add_vec("divu_zero",   OP_DIVU,  32'd5,        32'd0,        '0,           '0,           1'b1, 1'b1, 0);
        add_div("divu_10_3",   OP_DIVU,  32'd10,       32'd3,        32'd1,        32'd3);
        add_vec("div_zero",    OP_DIV,   32'd9,        32'd0,        '0,           '0,           1'b1, 1'b1, 0);

        // Clock/reset block
        Reset = 1'b1; bus.Start = 1'b0; bus.Op = 2'b00; bus.A = '0; bus.B = '0;
        repeat (3) tick();
        Reset = 1'b0;
        tick();
        check("reset_flags", {bus.Busy, bus.Done, bus.Err}, 3'b000);
        check("reset_hi", bus.Hi, 0);
        check("reset_lo", bus.Lo, 0);
        check("reset_state", bus.dbg_state, 2'd0);

        foreach (vecs[i]) begin
            v = vecs[i];
            run_vec(v);
        end

        // Start pulsed while busy must be dropped; Hi/Lo keep the old result
        start_op(OP_MULT, 32'd3, 32'd4);
        repeat (4) tick();
        bus.Start = 1'b1; bus.Op = OP_MULT; bus.A = 32'd5; bus.B = 32'd5;
        tick();
        bus.Start = 1'b0;
        check("busy_start_hold_hi", bus.Hi, prev_hi);
        check("busy_start_hold_lo", bus.Lo, prev_lo);
        wait_done(LAT + 8, prev_hi, prev_lo, lat, seen, hold_bad, err_bad);
        check("busy_start_done", seen, 1);
        check("busy_start_lat", 5 + lat, LAT);
        check("busy_start_hold", hold_bad, 0);
        check("busy_start_lo", bus.Lo, 12);
        check("busy_start_hi", bus.Hi, 0);
        prev_hi = '0; prev_lo = 32'd12;
        extra = 0;
        repeat (40) begin
            tick();
            if (bus.Done === 1'b1) extra++;
        end
        check("busy_start_single_done", extra, 0);
        check("busy_start_idle", bus.Busy, 0);

        // Reset during RUN discards the operation
        start_op(OP_MULT, 32'h1234, 32'h5678);
        repeat (9) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("midreset_flags", {bus.Busy, bus.Done, bus.Err}, 3'b000);
        check("midreset_hi", bus.Hi, 0);
        check("midreset_lo", bus.Lo, 0);
        check("midreset_state", bus.dbg_state, 2'd0);
        extra = 0;
        repeat (40) begin
            tick();
            if (bus.Done === 1'b1) extra++;
        end
        check("midreset_no_done", extra, 0);
        prev_hi = '0; prev_lo = '0;
        v.name = "after_reset"; v.op = OP_MULT; v.a = 32'd2; v.b = 32'd3;
        v.hi = 32'd0; v.lo = 32'd6; v.err = 1'b0; v.keep = 1'b0; v.lat = LAT;
        run_vec(v);

        // Start held high: the next operation is taken one idle cycle after Done
        bus.Start = 1'b1; bus.Op = OP_MULTU; bus.A = 32'd2; bus.B = 32'd3;
        tick();
        wait_done(LAT + 8, prev_hi, prev_lo, lat, seen, hold_bad, err_bad);
        check("held_first_lat", lat, LAT);
        check("held_first_lo", bus.Lo, 6);
        tick();
        check("held_gap_idle", bus.Busy, 0);
        tick();
        check("held_second_busy", bus.Busy, 1);
        bus.Start = 1'b0; bus.Op = OP_MULT; bus.A = 32'd100; bus.B = 32'd100;
        wait_done(LAT + 8, 32'd0, 32'd6, lat, seen, hold_bad, err_bad);
        check("held_second_lat", lat, LAT);
        check("held_second_hi", bus.Hi, 0);
        check("held_second_lo", bus.Lo, 6);
        check("held_second_err", bus.Err, 0);
        tick();
        check("held_end_idle", bus.Busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
